pipe_rr_arb: RTL and testbench
==============================

PIPE_RR_ARB -- requirements
Module: pipe_rr_arb

Interface
REQ-001 SHALL have parameter R, default 4: number of requesters, R >= 2.
REQ-002 SHALL have parameter W, default 32: payload width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all flops rise-edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_vld, input, R: per-requester valid.
REQ-006 SHALL have port req_data, input, R x W: per-requester payload, packed [R-1:0][W-1:0].
REQ-007 SHALL have port req_accept, output, R: per-requester accept; at most one bit set per cycle.
REQ-008 SHALL have port out_r, output, W: head payload, registered.
REQ-009 SHALL have port out_id_r, output, $clog2(R): requester index of the head entry, registered.
REQ-010 SHALL have port out_vld_r, output, 1: head valid, registered.
REQ-011 SHALL have port out_accept, input, 1: downstream accept; a pop happens when out_vld_r & out_accept.

Function
REQ-012 SHALL hold a 2-entry double buffer (head + skid) with occupancy occ in {EMPTY=0, ONE=1, FULL=2}.
REQ-013 SHALL derive can_accept = (occ != FULL) from flops only, with no combinational path from out_accept to req_accept.
REQ-014 SHALL select a grant round-robin: the first i with req_vld[i]=1, searching from ptr upward and wrapping R-1 -> 0.
REQ-015 SHALL drive req_accept[i] = can_accept & grant[i]; a push occurs when req_vld[i] & req_accept[i].
REQ-016 SHALL set ptr to (i+1) mod R on a push from i, and leave ptr unchanged otherwise (including a stalled grant).
REQ-017 SHALL treat req_data and req_vld of a non-accepted requester as don't-care, and SHALL NOT require requesters to hold valid.
REQ-018 SHALL have latency 1: a push at cycle t into EMPTY gives out_vld_r=1, out_r=data and out_id_r=i at t+1.
REQ-019 SHALL apply these occ transitions: EMPTY+push -> ONE; ONE+push, no pop -> FULL (skid loaded); ONE+pop, no push -> EMPTY; ONE+push+pop -> ONE (head loaded with new data).
REQ-020 SHALL apply these FULL transitions: FULL+pop -> ONE (head <- skid); no push is possible in FULL.
REQ-021 SHALL keep out_r and out_id_r stable while out_vld_r=1 and out_accept=0.
REQ-022 SHALL preserve order: entries leave in push order, with no loss or duplication.
REQ-023 SHALL ignore out_accept when out_vld_r=0.

Reset
REQ-024 SHALL, while rst=1, asynchronously force occ=EMPTY, out_vld_r=0, out_r=0, out_id_r=0, ptr=0 and skid contents=0.
REQ-025 SHALL drive req_accept=0 during rst=1, and SHALL discard any in-flight entries when reset is asserted mid-operation.
REQ-026 SHALL allow a push in the first cycle after rst deasserts.

Verification
REQ-027 SHALL cover: R=4, all req_vld=1, out_accept=1 always -> grants 0,1,2,3,0,... one per cycle, out_id_r sequence the same, 1-cycle lag.
REQ-028 SHALL cover: only req_vld[2]=1 with data 0xA5, buffer EMPTY, ptr=0 -> req_accept=4'b0100; next cycle out_r=0xA5, out_id_r=2, ptr=3.
REQ-029 SHALL cover: out_accept=0, req_vld[0..1]=1 -> two pushes then req_accept=0 (FULL); out_r held; on raising out_accept, pops occur in push order with no drop.
REQ-030 SHALL cover: occ=ONE with push and pop in the same cycle -> occ stays ONE and out_r takes the new data next cycle.
REQ-031 SHALL cover: rst pulsed mid-stream with occ=FULL and ptr=3 -> out_vld_r=0 immediately, ptr=0, and the first post-reset grant goes to the lowest valid index.
REQ-032 SHALL cover: random req_vld and out_accept over 10k cycles -> scoreboard order and data match, no requester starved beyond R-1 pushes by others.

Source files
------------

// File: rtl/pipe_rr_arb.sv
// pipe_rr_arb: round-robin arbiter feeding a two-entry head/skid output buffer.
// Requesters are granted in rotating priority starting at ptr. The winner's
// payload is pushed into a registered head slot, or into a skid slot when the
// head is still waiting on the downstream. Upstream accept depends only on the
// buffer occupancy flops, so out_accept never reaches req_accept combinationally.
module pipe_rr_arb #(
  parameter int R = 4,
  parameter int W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [R-1:0]              req_vld,
  input  logic [R-1:0][W-1:0]       req_data,
  output logic [R-1:0]              req_accept,
  output logic [W-1:0]              out_r,
  output logic [$clog2(R)-1:0]      out_id_r,
  output logic                      out_vld_r,
  input  logic                      out_accept
);

  localparam int ID_W = $clog2(R);
  localparam logic [ID_W:0]   R_W  = (ID_W+1)'(R);
  localparam logic [ID_W-1:0] LAST = ID_W'(R - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t            occ;
  logic [W-1:0]    skid_data;
  logic [ID_W-1:0] skid_id;
  logic [ID_W-1:0] ptr;

  logic [ID_W:0]   cand;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [R-1:0]    grant;
  logic [ID_W-1:0] next_ptr;
  logic [W-1:0]    push_data;
  logic            can_accept;
  logic            push;
  logic            pop;

  // Scan requesters from ptr upward, wrapping past R-1, and keep the first valid one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < R; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= R_W) begin
        cand = cand - R_W;
      end
      if (!grant_found && req_vld[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Turn the winning index into a one-hot grant vector.
  always_comb begin
    grant            = '0;
    grant[grant_idx] = grant_found;
  end

  // Room exists unless both slots hold data; reset also blocks any accept.
  assign can_accept = (occ != FULL);
  assign req_accept = grant & {R{can_accept & ~rst}};
  assign push       = grant_found & can_accept & ~rst;
  assign pop        = out_vld_r & out_accept;
  assign push_data  = req_data[grant_idx];
  assign next_ptr   = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;

  // Occupancy state machine moving entries between upstream, head and skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= EMPTY;
      out_r     <= '0;
      out_id_r  <= '0;
      out_vld_r <= 1'b0;
      skid_data <= '0;
      skid_id   <= '0;
      ptr       <= '0;
    end else begin
      if (push) begin
        ptr <= next_ptr;
      end
      case (occ)
        EMPTY: begin
          if (push) begin
            out_r     <= push_data;
            out_id_r  <= grant_idx;
            out_vld_r <= 1'b1;
            occ       <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_data <= push_data;
            skid_id   <= grant_idx;
            occ       <= FULL;
          end else if (pop && !push) begin
            out_vld_r <= 1'b0;
            occ       <= EMPTY;
          end else if (push && pop) begin
            out_r    <= push_data;
            out_id_r <= grant_idx;
          end
        end
        FULL: begin
          if (pop) begin
            out_r    <= skid_data;
            out_id_r <= skid_id;
            occ      <= ONE;
          end
        end
        default: begin
          occ       <= EMPTY;
          out_vld_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_rr_arb.sv
// tb_pipe_rr_arb: drives directed and random traffic into pipe_rr_arb and
// compares every cycle against a queue-based reference of the arbiter.
module tb_pipe_rr_arb;

  localparam int R  = 4;
  localparam int W  = 32;
  localparam int IW = $clog2(R);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [R-1:0]         req_vld;
  logic [R-1:0][W-1:0]  req_data;
  logic [R-1:0]         req_accept;
  logic [W-1:0]         out_r;
  logic [IW-1:0]        out_id_r;
  logic                 out_vld_r;
  logic                 out_accept;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } entry_t;

  entry_t q[$];
  int     m_ptr;
  int     wait_cnt[R];
  int     max_wait[R];
  int     total = 0;
  int     bad   = 0;

  pipe_rr_arb #(.R(R), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_data   (req_data),
    .req_accept (req_accept),
    .out_r      (out_r),
    .out_id_r   (out_id_r),
    .out_vld_r  (out_vld_r),
    .out_accept (out_accept)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: nothing is accepted once two entries are buffered,
  // otherwise the first valid requester at or after the pointer wins.
  function automatic int modelGrant();
    int i;
    if (q.size() >= 2) return -1;
    for (int k = 0; k < R; k++) begin
      i = (m_ptr + k) % R;
      if (req_vld[i]) return i;
    end
    return -1;
  endfunction

  // One cycle: drive inputs, check DUT against reference mid-cycle, advance reference.
  task automatic applyStimulus(input logic [R-1:0] vld, input logic acc, input bit fix_data);
    int           g;
    logic [R-1:0] exp_acc;
    req_vld    = vld;
    out_accept = acc;
    for (int i = 0; i < R; i++) begin
      req_data[i] = fix_data ? 32'h0000_00A5 : $urandom;
    end
    #3;
    g       = modelGrant();
    exp_acc = '0;
    if (g >= 0) exp_acc[g] = 1'b1;
    checkOutput("req_accept", 64'(req_accept), 64'(exp_acc));
    checkOutput("out_vld_r", 64'(out_vld_r), 64'(q.size() > 0));
    if (q.size() > 0) begin
      checkOutput("out_r", 64'(out_r), 64'(q[0].data));
      checkOutput("out_id_r", 64'(out_id_r), 64'(q[0].id));
    end
    for (int i = 0; i < R; i++) begin
      if (!vld[i] || g == i) begin
        wait_cnt[i] = 0;
      end else if (g >= 0) begin
        wait_cnt[i]++;
        if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
      end
    end
    if (q.size() > 0 && acc) q.delete(0);
    if (g >= 0) begin
      q.push_back('{g, req_data[g]});
      m_ptr = (g + 1) % R;
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle and verify outputs clear without waiting for a clock edge.
  task automatic pulseReset();
    rst        = 1'b1;
    req_vld    = '1;
    out_accept = 1'b1;
    #1;
    checkOutput("rst_async_vld", 64'(out_vld_r), 64'd0);
    checkOutput("rst_accept", 64'(req_accept), 64'd0);
    q.delete();
    m_ptr = 0;
    for (int i = 0; i < R; i++) wait_cnt[i] = 0;
    @(posedge clk);
    #1;
    checkOutput("rst_out_r", 64'(out_r), 64'd0);
    checkOutput("rst_out_id", 64'(out_id_r), 64'd0);
    rst = 1'b0;
  endtask

  // Test sequence.
  initial begin
    rst        = 1'b1;
    req_vld    = '0;
    out_accept = 1'b0;
    req_data   = '0;
    m_ptr      = 0;
    for (int i = 0; i < R; i++) begin
      wait_cnt[i] = 0;
      max_wait[i] = 0;
    end
    #2;
    checkOutput("reset_vld", 64'(out_vld_r), 64'd0);
    checkOutput("reset_out_r", 64'(out_r), 64'd0);
    checkOutput("reset_out_id", 64'(out_id_r), 64'd0);
    checkOutput("reset_accept", 64'(req_accept), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester 2 with fixed payload, then push+pop in the same cycle.
    applyStimulus(4'b0100, 1'b0, 1'b1);
    applyStimulus(4'b0101, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Everyone requesting with a free-flowing output.
    for (int c = 0; c < 10; c++) applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) applyStimulus(4'b0000, 1'b1, 1'b0);

    // Stalled output: fill both slots, hold, then drain in order.
    for (int c = 0; c < 4; c++) applyStimulus(4'b0011, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(4'b0000, 1'b1, 1'b0);

    // Fill with pointer left at 3, reset mid-stream, then confirm lowest index wins.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    pulseReset();
    applyStimulus(4'b1010, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(R'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b1, 1'b0);

    for (int i = 0; i < R; i++) begin
      checkOutput($sformatf("starve_%0d", i), 64'(max_wait[i] <= R - 1), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
